// File: rtl/serial_semiadder_seq.sv
// Bit-serial adder: a single half-adder cell is reused twice per bit
// (a_i + b_i, then partial sum + running carry) to form {cout, sum} = a + b.
// Start/busy/done handshake; sum/cout only change when an addition finishes.

// Half adder cell: C = a0 & b0, s0 = a0 ^ b0.
module semiadder (
  input  logic a0,
  input  logic b0,
  output logic c,
  output logic s0
);

  assign c  = a0 & b0;
  assign s0 = a0 ^ b0;

endmodule

module serial_semiadder_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Bit-index width is derived from WIDTH; kept local so it cannot drift.
  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    H1   = 2'd1,
    H2   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_sh;
  logic [WIDTH-1:0]  b_sh;
  logic [WIDTH-1:0]  res_sh;
  logic              carry;
  logic              p;
  logic              g;
  logic [IDXW-1:0]   idx;

  logic              cell_a;
  logic              cell_b;
  logic              cell_c;
  logic              cell_s;
  logic [WIDTH-1:0]  res_next;
  logic              carry_next;

  // Steer the shared cell: operand bits in H1, partial sum + carry in H2.
  always_comb begin
    cell_a = 1'b0;
    cell_b = 1'b0;
    case (state)
      H1: begin
        cell_a = a_sh[0];
        cell_b = b_sh[0];
      end
      H2: begin
        cell_a = p;
        cell_b = carry;
      end
      default: begin
        cell_a = 1'b0;
        cell_b = 1'b0;
      end
    endcase
  end

  semiadder u_cell (
    .a0 (cell_a),
    .b0 (cell_b),
    .c  (cell_c),
    .s0 (cell_s)
  );

  // Result shift-in at the MSB; written as shifts so WIDTH=1 needs no slice.
  always_comb begin
    res_next   = (res_sh >> 1) | (WIDTH'(cell_s) << (WIDTH - 1));
    carry_next = g | cell_c;
  end

  // Controller, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      p      <= 1'b0;
      g      <= 1'b0;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= 1'b0;
            idx    <= '0;
            res_sh <= '0;
            busy   <= 1'b1;
            state  <= H1;
          end
        end
        H1: begin
          p     <= cell_s;
          g     <= cell_c;
          state <= H2;
        end
        H2: begin
          res_sh <= res_next;
          carry  <= carry_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          if (idx == LAST_IDX) begin
            sum   <= res_next;
            cout  <= carry_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= H1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
